// File: rtl/cpu_bus_master_if.sv
// rtl/cpu_bus_master_if.sv - requester channels and bus arbitration handshake of cpu_bus_master
`timescale 1ns/1ps
interface cpu_bus_master_if #(
    parameter int N_CH = 2
);
    logic                bus_req;
    logic                bus_grant;
    logic                fc_bus;
    logic [N_CH-1:0]     ch_rd_req;
    logic [N_CH-1:0]     ch_wr_req;
    logic [N_CH*32-1:0]  ch_addr;
    logic [N_CH*32-1:0]  ch_wdata;
    logic [N_CH*2-1:0]   ch_size;
    logic [31:0]         ch_rdata;
    logic [N_CH-1:0]     ch_done;
    logic [N_CH-1:0]     ch_err;

    modport master (
        output bus_req,
        input  bus_grant, fc_bus,
        input  ch_rd_req, ch_wr_req, ch_addr, ch_wdata, ch_size,
        output ch_rdata, ch_done, ch_err
    );

    modport slave (
        input  bus_req,
        output bus_grant, fc_bus,
        output ch_rd_req, ch_wr_req, ch_addr, ch_wdata, ch_size,
        input  ch_rdata, ch_done, ch_err
    );
endinterface

// File: rtl/cpu_bus_master.sv
// rtl/cpu_bus_master.sv - round-robin multi-channel master on a shared tri-state system bus
// Define BUS_TIMEOUT_EN to abort XFER with an error after TIMEOUT_CYCLES cycles without fc_bus.
`timescale 1ns/1ps
module cpu_bus_master #(
    parameter int N_CH           = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    cpu_bus_master_if.master bus,
    output wire  [31:0]      addr_bus,
    inout  wire  [31:0]      data_bus,
    output wire  [3:0]       data_mask_bus,
    output wire              rd_bus,
    output wire              wr_bus
);
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [IDX_W:0] N_CH_W = (IDX_W+1)'(N_CH);
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
`ifdef BUS_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, XFER = 2'd2, DONE = 2'd3} state_t;
    state_t state_q, state_d;

    logic [IDX_W-1:0] ptr_q, sel_q, pick, ptr_next;
    logic [IDX_W:0]   pick_sum, ptr_inc;
    logic [31:0]      addr_q, wdata_q, rdata_q, rdata_c, size_mask;
    logic [1:0]       size_q;
    logic             wr_q, err_q;
    logic [TMO_W-1:0] tmo_q;
    logic             tmo_hit, in_xfer, found;
    logic [3:0]       lane_mask;
    logic [4:0]       byte_sh;
    logic [N_CH-1:0]  req_any, req_rot, done_vec;

    logic [31:0] addr_arr  [N_CH];
    logic [31:0] wdata_arr [N_CH];
    logic [1:0]  size_arr  [N_CH];
    logic        pick_rd, pick_wr, pick_illegal;
    logic [31:0] pick_addr, pick_wdata;
    logic [1:0]  pick_size;

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            addr_arr[k]  = bus.ch_addr[32*k +: 32];
            wdata_arr[k] = bus.ch_wdata[32*k +: 32];
            size_arr[k]  = bus.ch_size[2*k +: 2];
        end
    end

    // Rotate the request vector so bit 0 is the channel at the pointer.
    assign req_any = bus.ch_rd_req | bus.ch_wr_req;
    assign req_rot = N_CH'({req_any, req_any} >> ptr_q);

    always_comb begin
        found    = 1'b0;
        pick_sum = '0;
        for (int j = 0; j < N_CH; j++) begin
            if (!found && req_rot[j]) begin
                found    = 1'b1;
                pick_sum = {1'b0, ptr_q} + (IDX_W+1)'(j);
            end
        end
        if (pick_sum >= N_CH_W) pick_sum = pick_sum - N_CH_W;
        pick = pick_sum[IDX_W-1:0];
    end

    assign pick_rd    = bus.ch_rd_req[pick];
    assign pick_wr    = bus.ch_wr_req[pick];
    assign pick_addr  = addr_arr[pick];
    assign pick_wdata = wdata_arr[pick];
    assign pick_size  = size_arr[pick];

    always_comb begin
        pick_illegal = pick_rd && pick_wr;
        case (pick_size)
            2'b01:   if (pick_addr[0]) pick_illegal = 1'b1;
            2'b10:   if (pick_addr[1:0] != 2'b00) pick_illegal = 1'b1;
            2'b11:   pick_illegal = 1'b1;
            default: ;
        endcase
    end

    assign tmo_hit  = TMO_EN && (tmo_q == TMO_LAST);
    assign ptr_inc  = {1'b0, sel_q} + (IDX_W+1)'(1);
    assign ptr_next = (ptr_inc >= N_CH_W) ? '0 : ptr_inc[IDX_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        bus.bus_req = 1'b0;
        done_vec    = '0;
        case (state_q)
            IDLE: if (found) state_d = pick_illegal ? DONE : REQ;
            REQ: begin
                bus.bus_req = 1'b1;
                if (bus.bus_grant) state_d = XFER;
            end
            XFER: begin
                bus.bus_req = 1'b1;
                if (bus.fc_bus || tmo_hit) state_d = DONE;
                else if (!bus.bus_grant)   state_d = REQ;
            end
            DONE: begin
                done_vec[sel_q] = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
        bus.ch_done = done_vec;
        bus.ch_err  = err_q ? done_vec : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            tmo_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (found) begin
                    sel_q   <= pick;
                    addr_q  <= pick_addr;
                    wdata_q <= pick_wdata;
                    size_q  <= pick_size;
                    wr_q    <= pick_wr;
                    err_q   <= pick_illegal;
                end
                REQ: tmo_q <= '0;
                XFER: begin
                    if (bus.fc_bus) begin
                        if (!wr_q) rdata_q <= rdata_c;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                        if (tmo_hit) err_q <= 1'b1;
                    end
                end
                DONE: ptr_q <= ptr_next;
                default: ;
            endcase
        end
    end

    always_comb begin
        lane_mask = 4'b1111;
        size_mask = 32'hFFFF_FFFF;
        case (size_q)
            2'b00: begin lane_mask = 4'b0001; size_mask = 32'h0000_00FF; end
            2'b01: begin lane_mask = 4'b0011; size_mask = 32'h0000_FFFF; end
            default: ;
        endcase
    end

    // Bus pins are owned only while in XFER; elsewhere another master may drive them.
    assign in_xfer       = (state_q == XFER);
    assign byte_sh       = {addr_q[1:0], 3'b000};
    assign addr_bus      = in_xfer ? {addr_q[31:2], 2'b00} : 32'bz;
    assign data_mask_bus = in_xfer ? (lane_mask << addr_q[1:0]) : 4'bz;
    assign rd_bus        = in_xfer ? ~wr_q : 1'bz;
    assign wr_bus        = in_xfer ? wr_q : 1'bz;
    assign data_bus      = (in_xfer && wr_q) ? ((wdata_q & size_mask) << byte_sh) : 32'bz;
    assign rdata_c       = (data_bus >> byte_sh) & size_mask;
    assign bus.ch_rdata  = rdata_q;
endmodule

// File: tb/tb_cpu_bus_master.sv
// tb/tb_cpu_bus_master.sv - directed self-checking bench for cpu_bus_master
`timescale 1ns/1ps
module tb_cpu_bus_master;
`ifdef BUS_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    wire  [31:0] addr_bus;
    wire  [31:0] data_bus;
    wire  [3:0]  data_mask_bus;
    wire         rd_bus;
    wire         wr_bus;
    logic        tgt_drv = 1'b0;
    logic [31:0] tgt_data = 32'h0;
    int          checks = 0;
    int          failures = 0;
    int          ndone;
    logic [1:0]  seen;

    cpu_bus_master_if #(.N_CH(2)) bif ();

    cpu_bus_master #(.N_CH(2), .TIMEOUT_CYCLES(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bif),
        .addr_bus      (addr_bus),
        .data_bus      (data_bus),
        .data_mask_bus (data_mask_bus),
        .rd_bus        (rd_bus),
        .wr_bus        (wr_bus)
    );

    assign data_bus = tgt_drv ? tgt_data : 32'bz;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_ch(input logic k, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        bif.ch_rd_req[k]              = rd;
        bif.ch_wr_req[k]              = wr;
        bif.ch_addr[{k, 5'b0} +: 32]  = a;
        bif.ch_wdata[{k, 5'b0} +: 32] = d;
        bif.ch_size[{k, 1'b0} +: 2]   = sz;
    endtask

    task automatic wait_done(input string tag, input int max_cyc, output logic [1:0] got);
        int n = 0;
        got = 2'b00;
        while (got == 2'b00 && n < max_cyc) begin
            @(negedge clk);
            got = bif.ch_done;
            n++;
        end
        check({tag, "_in_time"}, {31'b0, got != 2'b00}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bif.bus_grant = 1'b0;
        bif.fc_bus    = 1'b0;
        bif.ch_rd_req = '0;
        bif.ch_wr_req = '0;
        bif.ch_addr   = '0;
        bif.ch_wdata  = '0;
        bif.ch_size   = '0;
        repeat (2) @(negedge clk);
        check("rst_bus_req", {31'b0, bif.bus_req}, 32'd0);
        check("rst_done", {30'b0, bif.ch_done}, 32'd0);
        check("rst_err", {30'b0, bif.ch_err}, 32'd0);
        check("rst_rdata", bif.ch_rdata, 32'd0);
        check("rst_addr_hiz", {31'b0, addr_bus === 32'bz}, 32'd1);
        check("rst_data_hiz", {31'b0, data_bus === 32'bz}, 32'd1);
        check("rst_strobe_hiz", {31'b0, (rd_bus === 1'bz) && (wr_bus === 1'bz) && (data_mask_bus === 4'bz)}, 32'd1);
        rst = 1'b0;

        // ch1 word read, minimum latency
        @(negedge clk);
        set_ch(1'b1, 1'b1, 1'b0, 32'h4000_0008, 32'h0, 2'b10);
        bif.bus_grant = 1'b1;
        bif.fc_bus    = 1'b1;
        tgt_drv       = 1'b1;
        tgt_data      = 32'hDEAD_BEEF;
        @(negedge clk);
        check("a_req_bus_req", {31'b0, bif.bus_req}, 32'd1);
        check("a_req_no_done", {30'b0, bif.ch_done}, 32'd0);
        @(negedge clk);
        check("a_addr", addr_bus, 32'h4000_0008);
        check("a_mask", {28'b0, data_mask_bus}, 32'hF);
        check("a_rd", {31'b0, rd_bus}, 32'd1);
        @(negedge clk);
        check("a_done_cycle3", {30'b0, bif.ch_done}, 32'd2);
        check("a_rdata", bif.ch_rdata, 32'hDEAD_BEEF);
        check("a_err", {30'b0, bif.ch_err}, 32'd0);
        set_ch(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        @(negedge clk);
        check("a_done_one_cycle", {30'b0, bif.ch_done}, 32'd0);
        check("a_rdata_hold", bif.ch_rdata, 32'hDEAD_BEEF);

        // ch1 byte write to lane 3
        tgt_drv    = 1'b0;
        bif.fc_bus = 1'b0;
        set_ch(1'b1, 1'b0, 1'b1, 32'h1000_0003, 32'h0000_00A5, 2'b00);
        @(negedge clk);
        check("b_req_wr_hiz", {31'b0, wr_bus === 1'bz}, 32'd1);
        @(negedge clk);
        check("b_mask", {28'b0, data_mask_bus}, 32'h8);
        check("b_data", data_bus, 32'hA500_0000);
        check("b_wr", {31'b0, wr_bus}, 32'd1);
        check("b_rd", {31'b0, rd_bus}, 32'd0);
        check("b_addr", addr_bus, 32'h1000_0000);
        bif.fc_bus = 1'b1;
        @(negedge clk);
        check("b_done", {30'b0, bif.ch_done}, 32'd2);
        check("b_err", {30'b0, bif.ch_err}, 32'd0);
        check("b_done_wr_hiz", {31'b0, wr_bus === 1'bz}, 32'd1);
        check("b_done_data_hiz", {31'b0, data_bus === 32'bz}, 32'd1);
        set_ch(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        bif.fc_bus = 1'b0;
        @(negedge clk);

        // both channels requesting continuously
        set_ch(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 2'b10);
        set_ch(1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 2'b10);
        bif.fc_bus = 1'b1;
        tgt_drv    = 1'b1;
        tgt_data   = 32'hCAFE_F00D;
        for (int i = 0; i < 4; i++) begin
            wait_done($sformatf("c_wait%0d", i), 20, seen);
            check($sformatf("c_order%0d", i), {30'b0, seen}, (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        set_ch(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        set_ch(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        bif.fc_bus = 1'b0;
        tgt_drv    = 1'b0;
        @(negedge clk);

        // grant withdrawn mid-XFER, request changed after latch
        set_ch(1'b1, 1'b1, 1'b0, 32'h2000_0004, 32'h0, 2'b10);
        @(negedge clk);
        @(negedge clk);
        check("e_addr_first", addr_bus, 32'h2000_0004);
        bif.bus_grant = 1'b0;
        set_ch(1'b1, 1'b1, 1'b0, 32'h3000_0000, 32'h0, 2'b10);
        @(negedge clk);
        check("e_back_req_bus_req", {31'b0, bif.bus_req}, 32'd1);
        check("e_back_req_rd_hiz", {31'b0, rd_bus === 1'bz}, 32'd1);
        bif.bus_grant = 1'b1;
        @(negedge clk);
        check("e_retry_addr", addr_bus, 32'h2000_0004);
        check("e_retry_rd", {31'b0, rd_bus}, 32'd1);
        bif.fc_bus = 1'b1;
        tgt_drv    = 1'b1;
        tgt_data   = 32'h0BAD_F00D;
        @(negedge clk);
        check("e_done", {30'b0, bif.ch_done}, 32'd2);
        check("e_rdata", bif.ch_rdata, 32'h0BAD_F00D);
        set_ch(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        bif.fc_bus = 1'b0;
        tgt_drv    = 1'b0;
        @(negedge clk);

        // misaligned half read is rejected without touching the bus
        set_ch(1'b0, 1'b1, 1'b0, 32'h1000_0001, 32'h0, 2'b01);
        @(negedge clk);
        check("d_ill_done", {30'b0, bif.ch_done}, 32'd1);
        check("d_ill_err", {30'b0, bif.ch_err}, 32'd1);
        check("d_ill_bus_req", {31'b0, bif.bus_req}, 32'd0);
        check("d_ill_addr_hiz", {31'b0, addr_bus === 32'bz}, 32'd1);
        set_ch(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        @(negedge clk);
        check("d_ill_pulse", {30'b0, bif.ch_done}, 32'd0);
        check("d_ill_err_pulse", {30'b0, bif.ch_err}, 32'd0);
        check("d_ill_bus_req_after", {31'b0, bif.bus_req}, 32'd0);

        // aligned upper-half read
        set_ch(1'b0, 1'b1, 1'b0, 32'h1000_0002, 32'h0, 2'b01);
        bif.fc_bus = 1'b1;
        tgt_drv    = 1'b1;
        tgt_data   = 32'h1234_0000;
        @(negedge clk);
        @(negedge clk);
        check("d_half_mask", {28'b0, data_mask_bus}, 32'hC);
        check("d_half_addr", addr_bus, 32'h1000_0000);
        @(negedge clk);
        check("d_half_done", {30'b0, bif.ch_done}, 32'd1);
        check("d_half_err", {30'b0, bif.ch_err}, 32'd0);
        check("d_half_rdata", bif.ch_rdata, 32'h0000_1234);
        set_ch(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        bif.fc_bus = 1'b0;
        tgt_drv    = 1'b0;
        @(negedge clk);

        // ch0 word write with fc never arriving
        set_ch(1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h1122_3344, 2'b10);
        @(negedge clk);
        @(negedge clk);
        check("f_wdata", data_bus, 32'h1122_3344);
        check("f_mask", {28'b0, data_mask_bus}, 32'hF);
`ifdef BUS_TIMEOUT_EN
        repeat (3) @(negedge clk);
        check("f_tmo_not_yet", {30'b0, bif.ch_done}, 32'd0);
        @(negedge clk);
        check("f_tmo_done", {30'b0, bif.ch_done}, 32'd1);
        check("f_tmo_err", {30'b0, bif.ch_err}, 32'd1);
        set_ch(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        @(negedge clk);
        set_ch(1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h1122_3344, 2'b10);
        @(negedge clk);
        @(negedge clk);
        check("f_rewrite_wr", {31'b0, wr_bus}, 32'd1);
`else
        ndone = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bif.ch_done != 2'b00) ndone++;
        end
        check("f_no_timeout_done", ndone, 32'd0);
        check("f_still_xfer", {31'b0, wr_bus}, 32'd1);
`endif
        #2 rst = 1'b1;
        #1;
        check("f_rst_bus_req", {31'b0, bif.bus_req}, 32'd0);
        check("f_rst_data_hiz", {31'b0, data_bus === 32'bz}, 32'd1);
        check("f_rst_wr_hiz", {31'b0, wr_bus === 1'bz}, 32'd1);
        check("f_rst_done", {30'b0, bif.ch_done}, 32'd0);
        set_ch(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        @(negedge clk);
        rst = 1'b0;

        // pointer restarts at channel 0 after reset
        set_ch(1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 2'b10);
        set_ch(1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 2'b10);
        bif.fc_bus = 1'b1;
        tgt_drv    = 1'b1;
        tgt_data   = 32'h5555_AAAA;
        wait_done("g_wait", 20, seen);
        check("g_ptr_reset_first", {30'b0, seen}, 32'd1);
        check("g_rdata", bif.ch_rdata, 32'h5555_AAAA);
        set_ch(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        set_ch(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        bif.fc_bus = 1'b0;
        tgt_drv    = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
